alu_sequencer: RTL and testbench

- Multi-cycle control FSM that drives the 64-bit ALU's 4-bit ALU_Control and the datapath enables around it.
- Samples the ALU Zero flag to resolve CBZ.
- Sits between the instruction register and the datapath. It issues one instruction at a time and waits on an instruction-valid handshake from instruction memory.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_sequencer_opcode_decoder.sv | 22 ++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings, opcode patterns, FSM states and instruction classes
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] MASK_CBZ = 11'b11111111000;
    localparam logic [10:0] OP_B     = 11'b00010100000;
    localparam logic [10:0] MASK_B   = 11'b11111100000;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    typedef enum logic [2:0] {R_TYPE, LOAD, STORE, CBZ, BRANCH, BAD} iclass_t;

    // true when the opcode bits selected by mask equal the pattern
    function automatic logic op_match(input logic [10:0] op, input logic [10:0] pat, input logic [10:0] mask);
        return (op & mask) == pat;
    endfunction

endpackage

// File: rtl/alu_sequencer_opcode_decoder.sv
// opcode_decoder: maps an 11-bit opcode to its instruction class and ALU operation
module opcode_decoder
    import alu_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     iclass,
    output logic [3:0]  alu_ctrl
);

    // classify the opcode; non-R-type instructions use the adder
    always_comb begin
        iclass   = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_AND || opcode == OP_ORR) ? R_TYPE :
                   opcode == OP_LDUR ? LOAD :
                   opcode == OP_STUR ? STORE :
                   op_match(opcode, OP_CBZ, MASK_CBZ) ? CBZ :
                   op_match(opcode, OP_B, MASK_B) ? BRANCH : BAD;
        alu_ctrl = opcode == OP_SUB ? ALU_SUB :
                   opcode == OP_AND ? ALU_AND :
                   opcode == OP_ORR ? ALU_OR : ALU_ADD;
    end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM driving the ALU and datapath enables
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Instr_Valid,
    input  logic [10:0]        Opcode,
    input  logic               Zero,
    output logic [3:0]         ALU_Control,
    output logic               ALU_Src,
    output logic               IR_Write,
    output logic               PC_Write,
    output logic               PC_Src,
    output logic               Reg_Write,
    output logic               Mem_Read,
    output logic               Mem_Write,
    output logic               Mem_To_Reg,
    output logic               Illegal,
    output logic [COUNT_W-1:0] Instr_Count
);

    logic [2:0]         state;
    logic [2:0]         state_nx;
    logic [10:0]        op_q;
    logic [COUNT_W-1:0] count_q;
    logic [3:0]         alu_op;
    logic               retire;
    iclass_t            cls;

    opcode_decoder u_dec (
        .opcode   (op_q),
        .iclass   (cls),
        .alu_ctrl (alu_op)
    );

    // next state from the current state and the class of the latched opcode
    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  state_nx = Instr_Valid ? S_DECODE : S_FETCH;
            S_DECODE: state_nx = cls == BAD ? S_ERROR : S_EXEC;
            S_EXEC:   state_nx = cls == R_TYPE ? S_WB : (cls == LOAD || cls == STORE) ? S_MEM : S_FETCH;
            S_MEM:    state_nx = cls == LOAD ? S_WB : S_FETCH;
            S_WB:     state_nx = S_FETCH;
            default:  state_nx = S_ERROR;
        endcase
    end

    assign retire = (state == S_EXEC && (cls == CBZ || cls == BRANCH)) ||
                    (state == S_MEM && cls == STORE) ||
                    state == S_WB;

    // state, opcode latch on the fetch handshake, and retired-instruction counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH && Instr_Valid)
                op_q <= Opcode;
            if (retire)
                count_q <= count_q + COUNT_W'(1);
        end
    end

    // datapath controls decode from state; reset forces every enable low
    always_comb begin
        ALU_Control = ALU_ADD;
        ALU_Src     = 1'b0;
        IR_Write    = 1'b0;
        PC_Write    = 1'b0;
        PC_Src      = 1'b0;
        Reg_Write   = 1'b0;
        Mem_Read    = 1'b0;
        Mem_Write   = 1'b0;
        Mem_To_Reg  = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ALU_Src  = 1'b1;
                    IR_Write = Instr_Valid;
                    PC_Write = Instr_Valid;
                end
                S_EXEC: begin
                    ALU_Control = cls == R_TYPE ? alu_op : ALU_ADD;
                    ALU_Src     = cls == LOAD || cls == STORE;
                    PC_Write    = cls == BRANCH || (cls == CBZ && Zero);
                    PC_Src      = cls == BRANCH || cls == CBZ;
                end
                S_MEM: begin
                    Mem_Read  = cls == LOAD;
                    Mem_Write = cls == STORE;
                end
                S_WB: begin
                    Reg_Write  = 1'b1;
                    Mem_To_Reg = cls == LOAD;
                end
                default: ;
            endcase
        end
    end

    assign Illegal     = state == S_ERROR;
    assign Instr_Count = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: table, directed and random checks of the sequencer against a cycle-list model
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Instr_Valid;
    logic [10:0] Opcode;
    logic        Zero;
    logic [3:0]  ALU_Control;
    logic        ALU_Src, IR_Write, PC_Write, PC_Src, Reg_Write, Mem_Read, Mem_Write, Mem_To_Reg, Illegal;
    logic [31:0] Instr_Count;
    logic [12:0] obs;
    logic [31:0] exp_cnt;
    int          checks = 0;
    int          errors = 0;

    localparam logic [10:0] T_ADD  = 11'b10001011000;
    localparam logic [10:0] T_SUB  = 11'b11001011000;
    localparam logic [10:0] T_AND  = 11'b10001010000;
    localparam logic [10:0] T_ORR  = 11'b10101010000;
    localparam logic [10:0] T_LDUR = 11'b11111000010;
    localparam logic [10:0] T_STUR = 11'b11111000000;
    localparam logic [12:0] M_ALL  = 13'h1FFD;
    localparam logic [12:0] M_EN   = 13'h00FD;
    localparam logic [12:0] M_WB   = 13'h00FF;
    localparam logic [12:0] M_NSRC = 13'h1EFD;

    alu_sequencer #(.COUNT_W(32)) dut (
        .clk(clk), .reset(reset), .Instr_Valid(Instr_Valid), .Opcode(Opcode), .Zero(Zero),
        .ALU_Control(ALU_Control), .ALU_Src(ALU_Src), .IR_Write(IR_Write), .PC_Write(PC_Write),
        .PC_Src(PC_Src), .Reg_Write(Reg_Write), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Mem_To_Reg(Mem_To_Reg), .Illegal(Illegal), .Instr_Count(Instr_Count)
    );

    always #5 clk = ~clk;

    assign obs = {ALU_Control, ALU_Src, IR_Write, PC_Write, PC_Src, Reg_Write, Mem_Read, Mem_Write, Mem_To_Reg, Illegal};

    typedef struct {
        logic [10:0] op;
        logic        z;
        logic        ca;
        logic [3:0]  alu;
        logic        src;
        logic        pcw;
        logic        pcs;
    } vec_t;

    function automatic logic [12:0] mk(input logic [3:0] a, input logic s, input logic ir, input logic pw,
                                       input logic ps, input logic rw, input logic mr, input logic mw,
                                       input logic m2r, input logic il);
        return {a, s, ir, pw, ps, rw, mr, mw, m2r, il};
    endfunction

    // 0 R-type, 1 load, 2 store, 3 cbz, 4 branch, 5 illegal
    function automatic int cls_of(input logic [10:0] op);
        casez (op)
            T_ADD, T_SUB, T_AND, T_ORR: return 0;
            T_LDUR:                     return 1;
            T_STUR:                     return 2;
            11'b10110100???:            return 3;
            11'b000101?????:            return 4;
            default:                    return 5;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [10:0] op);
        return op == T_SUB ? 4'b0110 : op == T_AND ? 4'b0000 : op == T_ORR ? 4'b0001 : 4'b0010;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [12:0] act, input logic [12:0] exp, input logic [12:0] m);
        checks++;
        if (((act ^ exp) & m) != 13'h0) begin
            errors++;
            $display("FAIL %s got=%b want=%b care=%b", nm, act, exp, m);
        end
    endtask

    // enter at posedge+1 with the DUT in FETCH; leave at posedge+1 back in FETCH (or ERROR for illegal)
    task automatic run_instr(input logic [10:0] op, input logic z, input int idle, output logic [12:0] exec_obs);
        logic [12:0] ex[4];
        logic [12:0] m[4];
        int          n;
        int          c;
        c = cls_of(op);
        exec_obs = '0;
        for (int i = 0; i < idle; i++) begin
            Instr_Valid = 1'b0;
            Opcode = 11'($urandom);
            Zero = 1'($urandom);
            @(negedge clk);
            chk_vec("idle", obs, mk(4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
            chk("idle_cnt", Instr_Count, exp_cnt);
            @(posedge clk); #1;
        end
        Instr_Valid = 1'b1;
        Opcode = op;
        Zero = 1'($urandom);
        @(negedge clk);
        chk_vec($sformatf("fetch_%b", op), obs, mk(4'b0010, 1, 1, 1, 0, 0, 0, 0, 0, 0), M_ALL);
        chk("fetch_cnt", Instr_Count, exp_cnt);
        @(posedge clk); #1;
        ex[0] = mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m[0] = M_EN;
        n = 1;
        case (c)
            0: begin
                ex[1] = mk(alu_of(op), 0, 0, 0, 0, 0, 0, 0, 0, 0); m[1] = M_ALL;
                ex[2] = mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 0, 0);    m[2] = M_WB;
                n = 3;
            end
            1: begin
                ex[1] = mk(4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0); m[1] = M_ALL;
                ex[2] = mk(4'b0010, 0, 0, 0, 0, 0, 1, 0, 0, 0); m[2] = M_EN;
                ex[3] = mk(4'b0010, 0, 0, 0, 0, 1, 0, 0, 1, 0); m[3] = M_WB;
                n = 4;
            end
            2: begin
                ex[1] = mk(4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0); m[1] = M_ALL;
                ex[2] = mk(4'b0010, 0, 0, 0, 0, 0, 0, 1, 0, 0); m[2] = M_EN;
                n = 3;
            end
            3: begin
                ex[1] = mk(4'b0010, 0, 0, z, 1, 0, 0, 0, 0, 0); m[1] = M_ALL;
                n = 2;
            end
            4: begin
                ex[1] = mk(4'b0010, 0, 0, 1, 1, 0, 0, 0, 0, 0); m[1] = M_EN;
                n = 2;
            end
            default: n = 1;
        endcase
        for (int i = 0; i < n; i++) begin
            Instr_Valid = 1'($urandom);
            Opcode = 11'($urandom);
            Zero = (i == 1) ? z : 1'($urandom);
            @(negedge clk);
            chk_vec($sformatf("cyc%0d_%b", i, op), obs, ex[i], m[i]);
            chk("cyc_cnt", Instr_Count, exp_cnt);
            if (i == 1)
                exec_obs = obs;
            @(posedge clk); #1;
        end
        if (c != 5)
            exp_cnt = exp_cnt + 32'd1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[9];
        logic [10:0] rops[4];
        logic [12:0] eo;
        logic [10:0] op;
        int          k;
        tbl[0] = '{T_ADD, 0, 1, 4'b0010, 0, 0, 0};
        tbl[1] = '{T_SUB, 0, 1, 4'b0110, 0, 0, 0};
        tbl[2] = '{T_ORR, 1, 1, 4'b0001, 0, 0, 0};
        tbl[3] = '{T_AND, 1, 1, 4'b0000, 0, 0, 0};
        tbl[4] = '{T_LDUR, 0, 1, 4'b0010, 1, 0, 0};
        tbl[5] = '{T_STUR, 1, 1, 4'b0010, 1, 0, 0};
        tbl[6] = '{11'b10110100101, 1, 1, 4'b0010, 0, 1, 1};
        tbl[7] = '{11'b10110100101, 0, 1, 4'b0010, 0, 0, 1};
        tbl[8] = '{11'b00010110011, 0, 0, 4'b0010, 0, 1, 1};
        rops = '{T_ADD, T_SUB, T_AND, T_ORR};
        reset = 1'b1;
        Instr_Valid = 1'b1;
        Opcode = T_ADD;
        Zero = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        chk_vec("reset_outs", obs, mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_NSRC);
        chk("reset_cnt", Instr_Count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(T_ADD, 0, 5, eo);
        chk("add_cnt", Instr_Count, 32'd1);
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].z, 0, eo);
            if (tbl[i].ca) begin
                chk($sformatf("tbl%0d_alu", i), eo[12:9], tbl[i].alu);
                chk($sformatf("tbl%0d_src", i), eo[8], tbl[i].src);
            end
            chk($sformatf("tbl%0d_pcw", i), eo[6], tbl[i].pcw);
            chk($sformatf("tbl%0d_pcs", i), eo[5], tbl[i].pcs);
        end
        for (int r = 0; r < 150; r++) begin
            k = $urandom_range(0, 4);
            op = k == 0 ? rops[$urandom_range(0, 3)] : k == 1 ? T_LDUR : k == 2 ? T_STUR :
                 k == 3 ? {8'b10110100, 3'($urandom)} : {6'b000101, 5'($urandom)};
            run_instr(op, 1'($urandom), $urandom_range(0, 2), eo);
        end
        Instr_Valid = 1'b1;
        Opcode = T_LDUR;
        @(posedge clk); #1;
        Instr_Valid = 1'b0;
        Opcode = T_ADD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mem_read_before_reset", Mem_Read, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mem_read_async_drop", Mem_Read, 1'b0);
        chk("reg_write_async", Reg_Write, 1'b0);
        chk("cnt_async_clear", Instr_Count, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_vec("held_reset", obs, mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_NSRC);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        chk_vec("post_reset_fetch", obs, mk(4'b0010, 1, 0, 0, 0, 0, 0, 0, 0, 0), M_ALL);
        chk("post_reset_cnt", Instr_Count, 32'd0);
        @(posedge clk); #1;
        run_instr(11'b11111111111, 0, 1, eo);
        for (int i = 0; i < 6; i++) begin
            Instr_Valid = 1'(i);
            Opcode = T_ADD;
            @(negedge clk);
            chk_vec("error_state", obs, mk(4'b0010, 0, 0, 0, 0, 0, 0, 0, 0, 1), M_NSRC);
            chk("error_cnt", Instr_Count, exp_cnt);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        chk("illegal_cleared", Illegal, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        Instr_Valid = 1'b0;
        exp_cnt = '0;
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("forced_cnt", Instr_Count, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        release dut.count_q;
        exp_cnt = 32'hFFFF_FFFF;
        run_instr(11'b00010100000, 0, 1, eo);
        run_instr(T_SUB, 0, 1, eo);
        chk("wrap_cnt", Instr_Count, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
